// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR stream generators: FSM state enum,
// default feedback masks for common widths and the fallback seed.
package lfsr_pkg;

    typedef enum logic [0:0] {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } lfsr_state_e;

    // Maximal-length masks for the left-shifting form; bit i selects state[i].
    localparam logic [63:0] LFSR_TAPS_8  = 64'h0000_0000_0000_00B8;
    localparam logic [63:0] LFSR_TAPS_16 = 64'h0000_0000_0000_B400;
    localparam logic [63:0] LFSR_TAPS_32 = 64'h0000_0000_B89A_DA1C;
    localparam logic [63:0] LFSR_TAPS_64 = 64'hD800_0000_0000_0000;

    localparam logic [63:0] LFSR_DEFAULT_SEED = 64'h0000_0000_FA11_4514;

endpackage

// File: rtl/lfsr_step.sv
// Combinational multi-step Fibonacci LFSR advance: applies STEPS single shifts
// of next = {state[WIDTH-2:0], ^(state & TAPS)} within one cycle.
module lfsr_step #(
    parameter int          WIDTH = 32,
    parameter logic [63:0] TAPS  = 64'h0000_0000_B89A_DA1C,
    parameter int          STEPS = 1
) (
    input  logic [WIDTH-1:0] i_state,
    output logic [WIDTH-1:0] o_state
);

    localparam logic [WIDTH-1:0] TAP_MASK = TAPS[WIDTH-1:0];

    logic [WIDTH-1:0] w_work;

    always_comb begin
        w_work = i_state;
        // NOTE: blocking assignments here chain each unrolled shift into the
        // next within the same evaluation; non-blocking would collapse to one.
        for (int k = 0; k < STEPS; k++) begin
            w_work = {w_work[WIDTH-2:0], ^(w_work & TAP_MASK)};
        end
        o_state = w_work;
    end

endmodule

// File: rtl/lfsr_stream_source.sv
// Parametrised LFSR random-word source with valid/ready output, runtime reseed
// and post-seed warm-up. Define LFSR_ZERO_RECOVER_EN for zero-state recovery.
module lfsr_stream_source
    import lfsr_pkg::*;
#(
    parameter int          WIDTH        = 32,
    parameter logic [63:0] TAPS         = LFSR_TAPS_32,
    parameter int          STEPS        = 1,
    parameter int          WARMUP       = 4,
    parameter logic [63:0] DEFAULT_SEED = LFSR_DEFAULT_SEED
) (
    input  logic             iClock,
    input  logic             iResetN,
    input  logic             iSeedLoad,
    input  logic [WIDTH-1:0] iSeed,
    input  logic             iReady,
    output logic             oValid,
    output logic [WIDTH-1:0] oValue,
    output logic             oBusy,
    output logic             oFault
);

    localparam logic [WIDTH-1:0] SEED_W     = DEFAULT_SEED[WIDTH-1:0];
    localparam logic [7:0]       WARMUP_CNT = 8'(WARMUP);
    // With no warm-up configured, every (re)start lands directly in RUN.
    localparam lfsr_state_e      ST_RESTART = (WARMUP == 0) ? ST_RUN : ST_WARMUP;

    lfsr_state_e      r_fsm;
    lfsr_state_e      w_fsm_next;
    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] w_state_next;
    logic [WIDTH-1:0] w_advanced;
    logic [7:0]       r_count;
    logic [7:0]       w_count_next;
`ifdef LFSR_ZERO_RECOVER_EN
    logic             r_fault;
    logic             w_fault_next;
`endif

    lfsr_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .STEPS (STEPS)
    ) u_step (
        .i_state (r_state),
        .o_state (w_advanced)
    );

    always_ff @(posedge iClock or negedge iResetN) begin
        if (!iResetN) begin
            r_fsm   <= ST_RESTART;
            r_state <= SEED_W;
            r_count <= WARMUP_CNT;
`ifdef LFSR_ZERO_RECOVER_EN
            r_fault <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            r_fsm   <= w_fsm_next;
            r_state <= w_state_next;
            r_count <= w_count_next;
`ifdef LFSR_ZERO_RECOVER_EN
            r_fault <= w_fault_next;
`endif
        end
    end

    always_comb begin
        // NOTE: every signal gets a hold default first so no path through the
        // branches below can leave one unassigned and infer a latch.
        w_fsm_next   = r_fsm;
        w_state_next = r_state;
        w_count_next = r_count;
`ifdef LFSR_ZERO_RECOVER_EN
        w_fault_next = 1'b0;
`endif
        if (iSeedLoad) begin
            // Reseed wins over a same-cycle fire; the consumer still took the old word.
            w_state_next = (iSeed == '0) ? SEED_W : iSeed;
            w_count_next = WARMUP_CNT;
            w_fsm_next   = ST_RESTART;
        end
`ifdef LFSR_ZERO_RECOVER_EN
        else if (r_state == '0) begin
            w_state_next = SEED_W;
            w_count_next = WARMUP_CNT;
            w_fsm_next   = ST_RESTART;
            w_fault_next = 1'b1;
        end
`endif
        else begin
            unique case (r_fsm)
                ST_WARMUP: begin
                    w_state_next = w_advanced;
                    w_count_next = r_count - 8'd1;
                    if (r_count == 8'd1) begin
                        w_fsm_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (iReady) begin
                        w_state_next = w_advanced;
                    end
                end
            endcase
        end
    end

    always_comb begin
        oValid = (r_fsm == ST_RUN);
        oBusy  = (r_fsm == ST_WARMUP);
        oValue = r_state;
`ifdef LFSR_ZERO_RECOVER_EN
        oFault = r_fault;
`else
        oFault = 1'b0;
`endif
    end

endmodule
